// File: rtl/rf_wb_pkg.sv
// Shared types and default sizing for the register-file writeback arbiter.
package rf_wb_pkg;
  localparam int DEF_BW     = 8;
  localparam int DEF_AW     = 4;
  localparam int DEF_DEPTH  = 2;
  localparam int DEF_STARVE = 3;

  typedef struct packed {
    logic [DEF_AW-1:0] rd;
    logic [DEF_BW-1:0] d;
  } wb_entry_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_P0, GNT_FIFO, GNT_BYP} gnt_e;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request/grant bus between the two sources, the register file and issue.
// RF_WB_FWD_EN adds the forwarding outputs.
interface rf_wb_arbiter_if #(parameter int bw = 8, parameter int aw = 4);
  logic          p0_valid, p0_ready;
  logic [aw-1:0] p0_rd;
  logic [bw-1:0] p0_d;
  logic          p1_valid, p1_ready;
  logic [aw-1:0] p1_rd;
  logic [bw-1:0] p1_d;
  logic [aw-1:0] rf_rd;
  logic [bw-1:0] rf_d;
  logic          rf_writed;
  logic [aw-1:0] ra_chk, rb_chk;
  logic          hazard, busy;
`ifdef RF_WB_FWD_EN
  logic          fwd_a_hit, fwd_b_hit;
  logic [bw-1:0] fwd_a, fwd_b;
`endif

  modport slave (
    input  p0_valid, p0_rd, p0_d, p1_valid, p1_rd, p1_d, ra_chk, rb_chk,
    output p0_ready, p1_ready, rf_rd, rf_d, rf_writed, hazard, busy
`ifdef RF_WB_FWD_EN
   ,output fwd_a_hit, fwd_b_hit, fwd_a, fwd_b
`endif
  );

  modport master (
    output p0_valid, p0_rd, p0_d, p1_valid, p1_rd, p1_d, ra_chk, rb_chk,
    input  p0_ready, p1_ready, rf_rd, rf_d, rf_writed, hazard, busy
`ifdef RF_WB_FWD_EN
   ,input  fwd_a_hit, fwd_b_hit, fwd_a, fwd_b
`endif
  );
endinterface

// File: rtl/rf_wb_fifo.sv
// Port-1 writeback FIFO; exposes all entries oldest-first (index 0 = head) for matching.
// RF_WB_FWD_EN adds the per-entry data view.
module rf_wb_fifo #(
  parameter int AW    = 4,
  parameter int BW    = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [AW-1:0]                din_rd,
  input  logic [BW-1:0]                din_d,
  output logic [AW-1:0]                head_rd,
  output logic [BW-1:0]                head_d,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0][AW-1:0]     ent_rd,
  output logic [DEPTH-1:0]             ent_vld
`ifdef RF_WB_FWD_EN
 ,output logic [DEPTH-1:0][BW-1:0]     ent_d
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int W  = AW + BW;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]             cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = {din_rd, din_d};
      wp_d        = wp_q + PW'(1);
    end
    if (pop) rp_d = rp_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head_rd = mem_q[rp_q][W-1:BW];
  assign head_d  = mem_q[rp_q][BW-1:0];

  // Rotate storage so consumers see age order without knowing the pointers.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i]  = mem_q[rp_q + PW'(i)][W-1:BW];
      ent_vld[i] = ((PW+1)'(i) < cnt_q);
`ifdef RF_WB_FWD_EN
      ent_d[i]   = mem_q[rp_q + PW'(i)][BW-1:0];
`endif
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU (priority) and a FIFO-buffered
// slow source with starvation guard. RF_WB_FWD_EN enables forwarding from buffered entries.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int bw     = DEF_BW,
  parameter int aw     = DEF_AW,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int STARVE = DEF_STARVE
) (
  input  logic             clk,
  input  logic             rst,
  rf_wb_arbiter_if.slave   bus
);
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [SW-1:0] SC_MAX = SW'(STARVE);

  gnt_e                    gnt;
  logic                    push, pop, full, empty, p1_rdy;
  logic [aw-1:0]           head_rd, sel_rd;
  logic [bw-1:0]           head_d, sel_d;
  logic [DEPTH-1:0][aw-1:0] ent_rd;
  logic [DEPTH-1:0]        ent_vld;
  logic [SW-1:0]           sc_q, sc_d;
`ifdef RF_WB_FWD_EN
  logic [DEPTH-1:0][bw-1:0] ent_d;
`endif

  rf_wb_fifo #(.AW(aw), .BW(bw), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din_rd  (bus.p1_rd),
    .din_d   (bus.p1_d),
    .head_rd (head_rd),
    .head_d  (head_d),
    .full    (full),
    .empty   (empty),
    .ent_rd  (ent_rd),
    .ent_vld (ent_vld)
`ifdef RF_WB_FWD_EN
   ,.ent_d   (ent_d)
`endif
  );

  // Reset forces GNT_NONE so every handshake/write output drops asynchronously.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst)                          gnt = GNT_NONE;
    else if (sc_q == SC_MAX && !empty) gnt = GNT_FIFO;
    else if (bus.p0_valid)             gnt = GNT_P0;
    else if (!empty)                   gnt = GNT_FIFO;
    else if (bus.p1_valid)             gnt = GNT_BYP;
  end

  assign pop    = (gnt == GNT_FIFO);
  assign p1_rdy = rst && (!full || pop);
  assign push   = bus.p1_valid && p1_rdy && (gnt != GNT_BYP);

  always_comb begin
    sel_rd = '0;
    sel_d  = '0;
    case (gnt)
      GNT_P0:   begin sel_rd = bus.p0_rd; sel_d = bus.p0_d; end
      GNT_FIFO: begin sel_rd = head_rd;   sel_d = head_d;   end
      GNT_BYP:  begin sel_rd = bus.p1_rd; sel_d = bus.p1_d; end
      default:  ;
    endcase
  end

  always_comb begin
    sc_d = sc_q;
    if (empty || pop)                          sc_d = '0;
    else if (gnt == GNT_P0 && sc_q != SC_MAX)  sc_d = sc_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sc_q <= '0;
    else      sc_q <= sc_d;
  end

  assign bus.p0_ready  = (gnt == GNT_P0);
  assign bus.p1_ready  = p1_rdy;
  assign bus.rf_rd     = sel_rd;
  assign bus.rf_d      = sel_d;
  // x0 writes still complete the handshake but never reach the register file.
  assign bus.rf_writed = (gnt != GNT_NONE) && (sel_rd != '0);
  assign bus.busy      = !empty;

`ifdef RF_WB_FWD_EN
  // Walk oldest to youngest so the last match is the youngest value.
  always_comb begin
    bus.fwd_a_hit = 1'b0;
    bus.fwd_b_hit = 1'b0;
    bus.fwd_a     = '0;
    bus.fwd_b     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && bus.ra_chk != '0 && ent_rd[i] == bus.ra_chk) begin
        bus.fwd_a_hit = 1'b1;
        bus.fwd_a     = ent_d[i];
      end
      if (ent_vld[i] && bus.rb_chk != '0 && ent_rd[i] == bus.rb_chk) begin
        bus.fwd_b_hit = 1'b1;
        bus.fwd_b     = ent_d[i];
      end
    end
  end
  assign bus.hazard = 1'b0;
`else
  always_comb begin
    bus.hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ((bus.ra_chk != '0 && ent_rd[i] == bus.ra_chk) ||
                         (bus.rb_chk != '0 && ent_rd[i] == bus.rb_chk)))
        bus.hazard = 1'b1;
    end
  end
`endif
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (rd/d/writed) between two writeback sources.
- Port 0: ALU result, single-cycle, priority. Port 1: slower source (load/mul-div), absorbed by a small FIFO.
- Grants drive the register-file write port combinationally; the write commits at the same clk edge.
- Provides a read-hazard check so the issue logic can stall reads of registers with writes still buffered.

Parameters:
- bw, 8, data width (matches register file)
- aw, 4, register address width
- DEPTH, 2, port-1 FIFO entries (power of two, >=2)
- STARVE, 3, consecutive cycles a non-empty FIFO head may lose to port 0 before forced grant

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- p0_valid  in  1  port-0 write request
- p0_ready  out  1  port-0 accepted this cycle
- p0_rd  in  aw  port-0 destination register
- p0_d  in  bw  port-0 data
- p1_valid  in  1  port-1 write request
- p1_ready  out  1  port-1 accepted this cycle
- p1_rd  in  aw  port-1 destination register
- p1_d  in  bw  port-1 data
- rf_rd  out  aw  to register file rd
- rf_d  out  bw  to register file d
- rf_writed  out  1  to register file writed
- ra_chk  in  aw  read address a under check
- rb_chk  in  aw  read address b under check
- hazard  out  1  a checked address has a pending buffered write
- busy  out  1  FIFO non-empty

Behaviour:
- Reset:
  - rst low asynchronously clears FIFO pointers/count and the starve counter.
  - While rst is low: p0_ready=0, p1_ready=0, rf_writed=0, hazard=0, busy=0.
  - Buffered entries are discarded. Reset mid-operation loses queued writes by design.
- Handshake: transfer when valid&&ready on a clk edge. Sources hold rd/d stable while valid&&!ready.
- State: FIFO (count 0..DEPTH) and starve counter sc (0..STARVE).
- Grant, per cycle, combinational:
  - sc==STARVE and FIFO non-empty: grant FIFO head; p0_ready=0.
  - Else if p0_valid: grant p0; p0_ready=1.
  - Else if FIFO non-empty: grant head.
  - Else if p1_valid (FIFO empty): bypass, write p1 directly without enqueue.
  - Else idle, rf_writed=0.
- p1_ready:
  - 1 when FIFO not full, or when full and the head dequeues this cycle.
  - A bypassed p1 is not enqueued.
  - Non-bypass p1 transfers enqueue at the tail. Enqueue and dequeue may occur in the same cycle; count unchanged.
- Starve counter:
  - Increments when the FIFO is non-empty and p0 wins.
  - Clears on FIFO dequeue or when the FIFO is empty.
  - Saturates at STARVE.
- Register 0: a granted write with rd==0 is consumed (handshake completes, entry dequeued) with rf_writed=0.
- rf_rd/rf_d reflect the granted source. They are don't-care when rf_writed=0 but must be driven (no X).
- hazard: 1 iff ra_chk or rb_chk (non-zero) equals rd of any valid FIFO entry. Incoming and bypass p1 are not checked.
- busy = (count != 0).
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH.

Optional Feature:
- Macro RF_WB_FWD_EN.
- Defined:
  - Adds outputs fwd_a_hit, fwd_b_hit (1) and fwd_a, fwd_b (bw).
  - Each carries the data of the youngest FIFO entry matching ra_chk/rb_chk.
  - hazard is then asserted only when a checked address matches but its forwarding is unavailable, which never occurs. hazard is tied to 0.
- Undefined: the forwarding ports are absent and hazard behaves as above.

Decomposition:
- Package rf_wb_pkg:
  - parameterised entry struct typedef wb_entry_t {rd, d}
  - grant-select enum {GNT_NONE, GNT_P0, GNT_FIFO, GNT_BYP}
  - default STARVE/DEPTH constants
- Sub-module rf_wb_fifo:
  - DEPTH-entry FIFO with push/pop/full/empty
  - exposes all entries plus valid vector for hazard/forward matching

Test Plan:
- Reset, p1 only: with rst low, drive p1_valid with rd=5, d=0x3C. Then release rst with FIFO empty and p0 idle -> same cycle rf_writed=1, rf_rd=5, rf_d=0x3C, p1_ready=1, busy stays 0.
- Collision: p0 (rd=2, d=0x11) and p1 (rd=3, d=0x22) valid together -> p0 written. p1 enqueued, busy=1. Next idle cycle FIFO writes rd=3, d=0x22.
- Starvation: FIFO holds rd=7. p0 valid every cycle with STARVE=3 -> p0 wins 3 cycles. 4th cycle p0_ready=0 and rd=7 is written. sc then clears.
- Full FIFO: fill 2 entries while p0 is continuously valid -> p1_ready=0. On a forced dequeue, p1_ready=1 that cycle and count stays 2.
- Hazard: FIFO holds rd=4. ra_chk=4 -> hazard=1. ra_chk=0 with an entry rd=0 -> hazard=0. The rd=0 entry dequeues with rf_writed=0.
- Async reset: assert rst mid-stream with 2 entries queued -> busy=0 and rf_writed=0 immediately without a clk edge. No queued write appears after release.
